// File: rtl/load_writeback_unit.sv
// Multi-cycle load path: execute -> word-aligned memory request -> extended register-file write.
// Optional macro LOAD_MISALIGN_TRAP_EN: trap misaligned LH/LHU/LW instead of aligning them down.
module load_writeback_unit #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [XLEN-1:0] ld_addr,
    input  logic [2:0]      ld_funct3,
    input  logic [AW-1:0]   ld_rd,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_err,
    output logic            reg_wr,
    output logic [AW-1:0]   waddr,
    output logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic [AW-1:0]   busy_rd,
    output logic            exc_valid,
    output logic [3:0]      exc_cause
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, EXC} state_e;

    localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
    localparam logic [3:0] CAUSE_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_FAULT    = 4'd5;

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [3:0]      cause_q, cause_d;

    logic            illegal;
    logic            misaligned;
    logic [XLEN-1:0] byte_sh;
    logic [XLEN-1:0] half_sh;
    logic [XLEN-1:0] ext_data;

    assign illegal = (ld_funct3 == 3'b011) || (ld_funct3 == 3'b110) || (ld_funct3 == 3'b111);

`ifdef LOAD_MISALIGN_TRAP_EN
    assign misaligned = ((ld_funct3[1:0] == 2'b01) && ld_addr[0]) ||
                        ((ld_funct3 == 3'b010) && (ld_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Little-endian lane select: shift the addressed byte/halfword down to bit 0.
    always_comb begin
        byte_sh = mem_rdata >> {addr_q[1:0], 3'b000};
        half_sh = mem_rdata >> {addr_q[1], 4'b0000};
        case (funct3_q)
            3'b000:  ext_data = {{(XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
            3'b100:  ext_data = {{(XLEN-8){1'b0}}, byte_sh[7:0]};
            3'b001:  ext_data = {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
            3'b101:  ext_data = {{(XLEN-16){1'b0}}, half_sh[15:0]};
            default: ext_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        data_d   = data_q;
        cause_d  = cause_q;
        case (state_q)
            IDLE: begin
                if (ld_valid) begin
                    addr_d   = ld_addr;
                    funct3_d = ld_funct3;
                    rd_d     = ld_rd;
                    if (illegal) begin
                        state_d = EXC;
                        cause_d = CAUSE_ILLEGAL;
                    end else if (misaligned) begin
                        state_d = EXC;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (mem_err) begin
                        state_d = EXC;
                        cause_d = CAUSE_FAULT;
                    end else begin
                        state_d = WB;
                        data_d  = ext_data;
                    end
                end
            end
            WB:      state_d = IDLE;
            EXC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            data_q   <= '0;
            cause_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            cause_q  <= cause_d;
        end
    end

    assign ld_ready  = (state_q == IDLE);
    assign mem_req   = (state_q == REQ);
    assign mem_addr  = (state_q == REQ) ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign reg_wr    = (state_q == WB) && (rd_q != '0);
    assign waddr     = (state_q == WB) ? rd_q : '0;
    assign wdata     = (state_q == WB) ? data_q : '0;
    assign busy      = (state_q != IDLE);
    assign busy_rd   = (state_q != IDLE) ? rd_q : '0;
    assign exc_valid = (state_q == EXC);
    assign exc_cause = (state_q == EXC) ? cause_q : '0;

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed self-checking bench for load_writeback_unit; expectations follow LOAD_MISALIGN_TRAP_EN.
module tb_load_writeback_unit;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            ld_valid;
    logic            ld_ready;
    logic [XLEN-1:0] ld_addr;
    logic [2:0]      ld_funct3;
    logic [AW-1:0]   ld_rd;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_err;
    logic            reg_wr;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic            busy;
    logic [AW-1:0]   busy_rd;
    logic            exc_valid;
    logic [3:0]      exc_cause;

    int n_vec = 0;
    int n_err = 0;

    // Observations gathered by run_load for one transaction.
    int          obs_wr, obs_wr_cyc, obs_exc, obs_req, obs_unstable, obs_bad_rd, obs_rdy_cyc;
    logic [31:0] obs_wd, obs_maddr;
    logic [4:0]  obs_wa;
    logic [3:0]  obs_cause;

    always #5 clk = ~clk;

    load_writeback_unit #(.XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_funct3(ld_funct3), .ld_rd(ld_rd),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata),
        .busy(busy), .busy_rd(busy_rd),
        .exc_valid(exc_valid), .exc_cause(exc_cause)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one load; cycle 1 is the cycle after the accepting edge. Ends on the first ld_ready.
    task automatic run_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                            input int gnt_dly, input int rv_dly,
                            input logic [31:0] rdata, input logic err);
        int  req_c;
        int  wait_c;
        bit  in_wait;
        bit  done;
        obs_wr = 0; obs_wr_cyc = -1; obs_exc = 0; obs_req = 0; obs_unstable = 0;
        obs_bad_rd = 0; obs_rdy_cyc = -1; obs_wd = '0; obs_maddr = '0; obs_wa = '0; obs_cause = '0;
        req_c = 0; wait_c = 0; in_wait = 0; done = 0;
        ld_valid = 1'b1; ld_addr = addr; ld_funct3 = f3; ld_rd = rd;
        for (int c = 1; c <= 60 && !done; c++) begin
            tick;
            ld_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
            if (ld_ready) begin
                obs_rdy_cyc = c;
                done = 1;
            end else begin
                if (busy_rd !== rd) obs_bad_rd++;
                if (reg_wr) begin obs_wr++; obs_wr_cyc = c; obs_wd = wdata; obs_wa = waddr; end
                if (exc_valid) begin obs_exc++; obs_cause = exc_cause; end
                if (mem_req) begin
                    if (obs_req == 0) obs_maddr = mem_addr;
                    else if (mem_addr !== obs_maddr) obs_unstable++;
                    obs_req++;
                    if (req_c == gnt_dly) begin mem_gnt = 1'b1; in_wait = 1; end
                    req_c++;
                end else if (in_wait) begin
                    if (wait_c == rv_dly) begin
                        mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err; in_wait = 0;
                    end
                    wait_c++;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        n_vec++; if (ld_ready !== 1'b1)  begin n_err++; $display("FAIL reset_ld_ready got %b want 1", ld_ready); end
        n_vec++; if (mem_req !== 1'b0)   begin n_err++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        n_vec++; if (mem_addr !== '0)    begin n_err++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        n_vec++; if (reg_wr !== 1'b0)    begin n_err++; $display("FAIL reset_reg_wr got %b want 0", reg_wr); end
        n_vec++; if (wdata !== '0 || waddr !== '0) begin n_err++; $display("FAIL reset_wport got %h/%h want 0/0", waddr, wdata); end
        n_vec++; if (busy !== 1'b0 || busy_rd !== '0) begin n_err++; $display("FAIL reset_busy got %b/%h want 0/0", busy, busy_rd); end
        n_vec++; if (exc_valid !== 1'b0 || exc_cause !== '0) begin n_err++; $display("FAIL reset_exc got %b/%h want 0/0", exc_valid, exc_cause); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_lw_basic;
        run_load(32'h100, 3'b010, 5'd5, 0, 0, 32'hDEADBEEF, 1'b0);
        n_vec++; if (obs_maddr !== 32'h100) begin n_err++; $display("FAIL lw_mem_addr got %h want 00000100", obs_maddr); end
        n_vec++; if (obs_req !== 1)        begin n_err++; $display("FAIL lw_req_cycles got %0d want 1", obs_req); end
        n_vec++; if (obs_wr !== 1 || obs_wr_cyc !== 3) begin n_err++; $display("FAIL lw_wr got %0d@%0d want 1@3", obs_wr, obs_wr_cyc); end
        n_vec++; if (obs_wa !== 5'd5)       begin n_err++; $display("FAIL lw_waddr got %0d want 5", obs_wa); end
        n_vec++; if (obs_wd !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_wdata got %h want deadbeef", obs_wd); end
        n_vec++; if (obs_bad_rd !== 0)      begin n_err++; $display("FAIL lw_busy_rd got %0d bad cycles want 0", obs_bad_rd); end
        n_vec++; if (obs_rdy_cyc !== 4)     begin n_err++; $display("FAIL lw_ready_cycle got %0d want 4", obs_rdy_cyc); end
    endtask

    task automatic test_extend;
        logic [31:0] addrs [7];
        logic [2:0]  f3s   [7];
        logic [31:0] exps  [7];
        addrs = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100, 32'h100};
        f3s   = '{3'b000,  3'b100,  3'b001,  3'b101,  3'b000,  3'b001,  3'b100};
        exps  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF,
                  32'h00000012, 32'h00001234, 32'h00000034};
        for (int i = 0; i < 7; i++) begin
            run_load(addrs[i], f3s[i], 5'd9, 0, 0, 32'h80FF1234, 1'b0);
            n_vec++;
            if (obs_wr !== 1 || obs_wd !== exps[i]) begin
                n_err++;
                $display("FAIL extend_%0d got wr=%0d data=%h want wr=1 data=%h", i, obs_wr, obs_wd, exps[i]);
            end
        end
    endtask

    task automatic test_stall;
        run_load(32'h2468, 3'b010, 5'd7, 3, 4, 32'h0BADF00D, 1'b0);
        n_vec++; if (obs_req !== 4 || obs_unstable !== 0) begin n_err++; $display("FAIL stall_req got %0d cycles %0d changes want 4/0", obs_req, obs_unstable); end
        n_vec++; if (obs_maddr !== 32'h2468) begin n_err++; $display("FAIL stall_mem_addr got %h want 00002468", obs_maddr); end
        n_vec++; if (obs_wr !== 1 || obs_wr_cyc !== 10) begin n_err++; $display("FAIL stall_wr got %0d@%0d want 1@10", obs_wr, obs_wr_cyc); end
        n_vec++; if (obs_wd !== 32'h0BADF00D) begin n_err++; $display("FAIL stall_wdata got %h want 0badf00d", obs_wd); end
        n_vec++; if (obs_rdy_cyc !== 11) begin n_err++; $display("FAIL stall_ready_cycle got %0d want 11", obs_rdy_cyc); end
    endtask

    task automatic test_rd_zero;
        run_load(32'h40, 3'b010, 5'd0, 0, 0, 32'h12345678, 1'b0);
        n_vec++; if (obs_wr !== 0)      begin n_err++; $display("FAIL rd0_no_write got %0d writes want 0", obs_wr); end
        n_vec++; if (obs_rdy_cyc !== 4) begin n_err++; $display("FAIL rd0_ready_cycle got %0d want 4", obs_rdy_cyc); end
    endtask

    task automatic test_access_fault;
        run_load(32'h300, 3'b010, 5'd3, 0, 1, 32'hFFFFFFFF, 1'b1);
        n_vec++; if (obs_exc !== 1 || obs_cause !== 4'd5) begin n_err++; $display("FAIL fault_exc got %0d cause %0d want 1 cause 5", obs_exc, obs_cause); end
        n_vec++; if (obs_wr !== 0)      begin n_err++; $display("FAIL fault_no_write got %0d want 0", obs_wr); end
        n_vec++; if (obs_rdy_cyc !== 5) begin n_err++; $display("FAIL fault_ready_cycle got %0d want 5", obs_rdy_cyc); end
    endtask

    task automatic test_illegal;
        logic [2:0] bad [3];
        bad = '{3'b111, 3'b011, 3'b110};
        for (int i = 0; i < 3; i++) begin
            run_load(32'h100, bad[i], 5'd4, 0, 0, 32'h0, 1'b0);
            n_vec++;
            if (obs_exc !== 1 || obs_cause !== 4'd2 || obs_req !== 0 || obs_wr !== 0 || obs_rdy_cyc !== 2) begin
                n_err++;
                $display("FAIL illegal_f3_%0d got exc=%0d cause=%0d req=%0d wr=%0d rdy=%0d want 1/2/0/0/2",
                         i, obs_exc, obs_cause, obs_req, obs_wr, obs_rdy_cyc);
            end
        end
    endtask

    task automatic test_misalign;
        run_load(32'h102, 3'b010, 5'd6, 0, 0, 32'hCAFEBABE, 1'b0);
`ifdef LOAD_MISALIGN_TRAP_EN
        n_vec++; if (obs_exc !== 1 || obs_cause !== 4'd4) begin n_err++; $display("FAIL misalign_exc got %0d cause %0d want 1 cause 4", obs_exc, obs_cause); end
        n_vec++; if (obs_req !== 0 || obs_wr !== 0) begin n_err++; $display("FAIL misalign_quiet got req=%0d wr=%0d want 0/0", obs_req, obs_wr); end
`else
        n_vec++; if (obs_maddr !== 32'h100 || obs_exc !== 0) begin n_err++; $display("FAIL misalign_addr got %h exc=%0d want 00000100 exc=0", obs_maddr, obs_exc); end
        n_vec++; if (obs_wr !== 1 || obs_wd !== 32'hCAFEBABE) begin n_err++; $display("FAIL misalign_write got %0d/%h want 1/cafebabe", obs_wr, obs_wd); end
`endif
    endtask

    task automatic test_back_to_back;
        run_load(32'h10, 3'b010, 5'd1, 0, 0, 32'h11111111, 1'b0);
        run_load(32'h14, 3'b010, 5'd2, 0, 0, 32'h22222222, 1'b0);
        n_vec++;
        if (obs_wr !== 1 || obs_wr_cyc !== 3 || obs_wa !== 5'd2 || obs_wd !== 32'h22222222) begin
            n_err++;
            $display("FAIL b2b_second got wr=%0d@%0d addr=%0d data=%h want 1@3 2 22222222", obs_wr, obs_wr_cyc, obs_wa, obs_wd);
        end
    endtask

    task automatic test_reset_mid;
        int wr_seen;
        wr_seen = 0;
        ld_valid = 1'b1; ld_addr = 32'h500; ld_funct3 = 3'b010; ld_rd = 5'd8;
        tick;                          // REQ
        ld_valid = 1'b0; mem_gnt = 1'b1;
        tick;                          // WAIT
        mem_gnt = 1'b0;
        n_vec++; if (busy_rd !== 5'd8) begin n_err++; $display("FAIL rstmid_busy_rd got %0d want 8", busy_rd); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h55555555; mem_err = 1'b0;
        tick;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (reg_wr || exc_valid) wr_seen++;
            n_vec++;
            if (ld_ready !== 1'b1 || busy !== 1'b0 || busy_rd !== '0 || mem_req !== 1'b0 || wdata !== '0) begin
                n_err++;
                $display("FAIL rstmid_idle_%0d got rdy=%b busy=%b rd=%0d req=%b wdata=%h want 1/0/0/0/0",
                         i, ld_ready, busy, busy_rd, mem_req, wdata);
            end
            tick;
        end
        n_vec++; if (wr_seen !== 0) begin n_err++; $display("FAIL rstmid_no_write got %0d pulses want 0", wr_seen); end
    endtask

    initial begin
        rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_funct3 = '0; ld_rd = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        test_reset;
        test_lw_basic;
        test_extend;
        test_stall;
        test_rd_zero;
        test_access_fault;
        test_illegal;
        test_misalign;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
